div_seq_32: RTL and testbench

Sequential signed 32-bit divider for the DIV instruction.
- Sits directly upstream of the HI and LO 32-bit datapath registers: `remainder` drives the HI register input, `quotient` drives the LO register input, and `done` drives both register enables.
- Computes one quotient bit per clock with restoring division on operand magnitudes, then applies a sign correction.
- The control unit starts it with a one-cycle `start` and waits for `done`.

---
 rtl/div_seq_32_pkg.sv | 23 ++
 rtl/div_seq_32_div_step.sv | 22 ++
 rtl/div_seq_32.sv | 103 ++++++++++
 tb/tb_div_seq_32.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/div_seq_32_pkg.sv
// Shared definitions for the sequential signed divider: width, state encoding
// and the divide-by-zero quotient constant.
package div_seq_32_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int CNT_W      = 6;

   localparam logic [DATA_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
   localparam logic [CNT_W-1:0]      LAST_CNT      = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } div_state_t;

   // Two's-complement magnitude; -2^31 maps to 0x80000000 as unsigned.
   function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v);
      return v[DATA_WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_seq_32_div_step.sv
// One restoring-division step: shift in the next dividend bit and
// trial-subtract the divisor magnitude from the partial remainder.
module div_step
   import div_seq_32_pkg::*;
(
   input  logic [DATA_WIDTH:0]   rem_in,
   input  logic                  dvd_bit,
   input  logic [DATA_WIDTH-1:0] dvs_mag,
   output logic [DATA_WIDTH:0]   rem_out,
   output logic                  q_bit
);

   logic [DATA_WIDTH+1:0] shifted;
   logic [DATA_WIDTH+1:0] diff;

   // One extra guard bit so the borrow is a clean sign bit of the difference.
   assign shifted = {rem_in, dvd_bit};
   assign diff    = shifted - {2'b00, dvs_mag};
   assign q_bit   = ~diff[DATA_WIDTH+1];
   assign rem_out = q_bit ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];

endmodule

// File: rtl/div_seq_32.sv
// Sequential signed 32-bit divider feeding HI (remainder) and LO (quotient);
// one quotient bit per clock, then a sign-correction cycle.
//
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | 32 restoring-division steps
//   FIX   | sign correction, results written
//   DONE  | done pulse (HI/LO enable), new start accepted
module div_seq_32
   import div_seq_32_pkg::*;
(
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  busy,
   output logic                  done,
   output logic                  div_by_zero,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);

   div_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH:0]   acc_q;
   logic [DATA_WIDTH-1:0] dq_q;
   logic [DATA_WIDTH-1:0] dvs_q;
   logic                  neg_quo_q;
   logic                  neg_rem_q;
   logic [DATA_WIDTH:0]   step_rem;
   logic                  step_bit;
   logic                  accept;
   logic                  dvs_zero;

   div_step u_step (
      .rem_in  (acc_q),
      .dvd_bit (dq_q[DATA_WIDTH-1]),
      .dvs_mag (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   assign dvs_zero = (divisor == '0);
   assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign busy     = (state_q == ST_RUN) || (state_q == ST_FIX);
   assign done     = (state_q == ST_DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE,
         ST_DONE: begin
            if (start)
               state_d = dvs_zero ? ST_DONE : ST_RUN;
            else
               state_d = ST_IDLE;
         end
         ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         dq_q        <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            dq_q        <= magnitude(dividend);
            dvs_q       <= magnitude(divisor);
            neg_quo_q   <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            neg_rem_q   <= dividend[DATA_WIDTH-1];
            div_by_zero <= dvs_zero;
            if (dvs_zero) begin
               quotient  <= DIV0_QUOTIENT;
               remainder <= dividend;
            end
         end else if (state_q == ST_RUN) begin
            acc_q <= step_rem;
            dq_q  <= {dq_q[DATA_WIDTH-2:0], step_bit};
            cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
         end else if (state_q == ST_FIX) begin
            // Truncating division: remainder follows the dividend's sign.
            quotient  <= neg_quo_q ? (~dq_q + 1'b1) : dq_q;
            remainder <= neg_rem_q ? (~acc_q[DATA_WIDTH-1:0] + 1'b1) : acc_q[DATA_WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32: directed vector table plus
// back-to-back, ignored-start and mid-run reset sequences.
module tb_div_seq_32;

   logic        clock;
   logic        clear_n;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] prev_q = 32'h0;
   logic [31:0] prev_r = 32'h0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } vec_t;

   vec_t vecs[13];

   div_seq_32 dut (
      .clock       (clock),
      .clear_n     (clear_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .quotient    (quotient),
      .remainder   (remainder)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; start is accepted on the following posedge.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez, input int inject_at);
      int lat;
      logic busy_ok;
      lat     = -1;
      busy_ok = 1'b1;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc == 0 && !ez) begin
            chk("hold_quotient", quotient, prev_q);
            chk("hold_remainder", remainder, prev_r);
            chk("div_by_zero_cleared", 32'(div_by_zero), 32'h0);
         end
         if (done) begin
            lat = cyc;
            if (busy) busy_ok = 1'b0;
            break;
         end
         if (!busy) busy_ok = 1'b0;
         if (cyc == inject_at) begin
            dividend = 32'd50;
            divisor  = 32'd5;
            start    = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clock);
      end
      start = 1'b0;
      chk("done_latency", 32'(lat), ez ? 32'd0 : 32'd33);
      chk("busy_window", 32'(busy_ok), 32'h1);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_by_zero", 32'(div_by_zero), 32'(ez));
      prev_q = eq;
      prev_r = er;
   endtask

   initial begin
      logic saw_done;
      vecs[0]  = '{32'd100,        32'd7,          32'h0000000E, 32'd2,        1'b0};
      vecs[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
      vecs[2]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2, 32'd2,        1'b0};
      vecs[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 1'b0};
      vecs[4]  = '{32'd5,          32'd0,          32'hFFFFFFFF, 32'd5,        1'b1};
      vecs[5]  = '{32'd6,          32'd3,          32'd2,        32'd0,        1'b0};
      vecs[6]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'd0,        1'b0};
      vecs[7]  = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 32'd0,        1'b0};
      vecs[8]  = '{32'd0,          32'd5,          32'd0,        32'd0,        1'b0};
      vecs[9]  = '{32'd7,          32'd100,        32'd0,        32'd7,        1'b0};
      vecs[10] = '{32'h80000000,   32'h80000000,   32'd1,        32'd0,        1'b0};
      vecs[11] = '{32'hFFFFFFFF,   32'd2,          32'd0,        32'hFFFFFFFF, 1'b0};
      vecs[12] = '{32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1};

      clear_n  = 1'b0;
      start    = 1'b0;
      dividend = 32'h0;
      divisor  = 32'h0;
      repeat (3) @(negedge clock);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
      chk("reset_div_by_zero", 32'(div_by_zero), 32'h0);
      chk("reset_quotient", quotient, 32'h0);
      chk("reset_remainder", remainder, 32'h0);
      clear_n = 1'b1;
      @(negedge clock);

      foreach (vecs[i]) begin
         do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, -1);
         @(negedge clock);
         chk("done_single_pulse", 32'(done), 32'h0);
      end

      // Back-to-back: second start issued during the done cycle.
      do_div(32'd6, 32'd3, 32'd2, 32'd0, 1'b0, -1);
      do_div(32'd100, 32'd7, 32'h0000000E, 32'd2, 1'b0, -1);
      @(negedge clock);

      // Start pulsed while busy is ignored.
      do_div(32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 5);
      @(negedge clock);

      // Reset in the middle of RUN aborts the division.
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(negedge clock);
      clear_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_done", 32'(done), 32'h0);
      chk("abort_quotient", quotient, 32'h0);
      chk("abort_remainder", remainder, 32'h0);
      @(negedge clock);
      clear_n  = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", 32'(saw_done), 32'h0);
      prev_q = 32'h0;
      prev_r = 32'h0;
      do_div(32'd20, 32'd6, 32'd3, 32'd2, 1'b0, -1);
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
